// File: rtl/fp_accum_seq_if.sv
// Bundle for the fp16 accumulator: operand stream in, adder loop, packet result out.
// Both streams use valid/ready: a transfer happens on the rising clk edge where valid
// and ready are both 1; a source holds valid and its payload until that edge.
interface fp_accum_seq_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic [15:0]      add_res;
    logic             add_v;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;
    logic [1:0]       state;

    // Environment side: operand source, fp_adder and result sink.
    modport master (
        output in_valid, in_data, in_last, add_res, add_v, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_sum, out_ovf, out_count, state
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_data, in_last, add_res, add_v, out_ready,
        output in_ready, add_a, add_b, out_valid, out_sum, out_ovf, out_count, state
    );
endinterface

// File: rtl/fp_accum_seq.sv
// Sequential binary16 accumulator wrapped around an external combinational fp_adder.
// Each accepted beat registers the adder result as the new running sum.
module fp_accum_seq #(
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          rst,
    fp_accum_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nx;
    logic [15:0]      acc, acc_nx;
    logic             ovf, ovf_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic             out_valid, out_valid_nx;
    logic [15:0]      out_sum, out_sum_nx;
    logic             out_ovf, out_ovf_nx;
    logic [CNT_W-1:0] out_count, out_count_nx;

    logic             accept;
    logic             ovf_upd;
    logic [CNT_W-1:0] count_upd;

    assign bus.in_ready  = (state != HOLD);
    assign bus.add_b     = bus.in_data;
    // The first beat of a packet is added to zero, so a stale acc never leaks in.
    assign bus.add_a     = (state == IDLE) ? 16'h0000 : acc;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum;
    assign bus.out_ovf   = out_ovf;
    assign bus.out_count = out_count;
    assign bus.state     = state;

    assign accept    = bus.in_valid && (state != HOLD);
    assign ovf_upd   = (state == IDLE) ? bus.add_v : (ovf | bus.add_v);
    assign count_upd = (state == IDLE)     ? CNT_ONE :
                       (count == CNT_MAX)  ? count   : count + CNT_ONE;

    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        ovf_nx       = ovf;
        count_nx     = count;
        out_valid_nx = out_valid;
        out_sum_nx   = out_sum;
        out_ovf_nx   = out_ovf;
        out_count_nx = out_count;

        case (state)
            IDLE, ACC: begin
                if (accept) begin
                    acc_nx   = bus.add_res;
                    ovf_nx   = ovf_upd;
                    count_nx = count_upd;
                    if (bus.in_last) begin
                        state_nx     = HOLD;
                        out_valid_nx = 1'b1;
                        out_sum_nx   = bus.add_res;
                        out_ovf_nx   = ovf_upd;
                        out_count_nx = count_upd;
                    end else begin
                        state_nx = ACC;
                    end
                end
            end
            HOLD: begin
                // Result registers stay untouched so the downstream sees a stable payload.
                if (bus.out_ready) begin
                    state_nx     = IDLE;
                    out_valid_nx = 1'b0;
                    acc_nx       = 16'h0000;
                    ovf_nx       = 1'b0;
                    count_nx     = '0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 16'h0000;
            ovf       <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            out_sum   <= 16'h0000;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            ovf       <= ovf_nx;
            count     <= count_nx;
            out_valid <= out_valid_nx;
            out_sum   <= out_sum_nx;
            out_ovf   <= out_ovf_nx;
            out_count <= out_count_nx;
        end
    end
endmodule

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
Sequential accumulation controller placed around the team's combinational half-precision adder (fp_adder). It accepts a stream of IEEE-754 binary16 operands over a valid/ready handshake and drives each operand into the adder together with the running sum. It registers the adder result as the new running sum and, at packet end, presents the final sum, an overflow flag and a beat count downstream. The adder sits combinationally between the add_* output and input ports.

Parameters:
CNT_W, 8, width of the beat counter; the count saturates at 2^CNT_W-1.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat
in_data  input  16  binary16 operand {sign, exp[4:0], mant[9:0]}
in_last  input  1  marks the final beat of a packet; qualified by in_valid & in_ready
add_a  output  16  running-sum operand to fp_adder input a
add_b  output  16  stream operand to fp_adder input b
add_res  input  16  fp_adder res
add_v  input  1  fp_adder overflow V
out_valid  output  1  packet result valid
out_ready  input  1  downstream accepts the result
out_sum  output  16  final accumulated binary16 sum
out_ovf  output  1  sticky: at least one accepted beat produced add_v=1 in this packet
out_count  output  CNT_W  number of beats accepted in the packet (saturating)

Behaviour:
Reset:
- One clk with rst=1 puts the block in state IDLE.
- Reset values: acc=16'h0000, ovf=0, count=0, out_valid=0, out_sum=16'h0000, out_ovf=0, out_count=0.
- rst has priority over every other event. Reset mid-packet discards the partial sum and the count. Reset in HOLD drops the pending result without a handshake.

States:
- IDLE: no beat accepted yet in the current packet.
- ACC: at least one beat accepted; in_last not yet seen.
- HOLD: result presented and waiting for out_ready.

Combinational outputs:
- in_ready = (state != HOLD).
- add_b = in_data.
- add_a = 16'h0000 in IDLE; add_a = acc otherwise.

Beat acceptance (in_valid & in_ready):
- acc <= add_res.
- ovf <= ovf | add_v. In IDLE, ovf <= add_v.
- count <= count+1, saturating at 2^CNT_W-1. In IDLE, count <= 1.
- If in_last=0, next state is ACC.
- If in_last=1:
  - next state is HOLD;
  - out_sum <= add_res;
  - out_ovf <= (IDLE ? add_v : ovf|add_v);
  - out_count <= the updated count;
  - out_valid <= 1.
- Latency: out_valid rises in the cycle after the in_last beat is accepted.
- A single-beat packet (IDLE with in_last=1) yields 0 + x.

Other cycles:
- No beat accepted: all registers hold.
- Once overflow occurs, acc holds whatever the adder returns (±inf pattern). No further saturation logic lives in this block.

HOLD:
- out_sum, out_ovf and out_count are stable while out_valid=1.
- On out_valid & out_ready: out_valid <= 0, acc <= 0, ovf <= 0, count <= 0, next state IDLE.
- in_ready=0 throughout HOLD, including the handshake cycle. A beat presented in that cycle is accepted no earlier than the following cycle.
- out_valid never drops without out_ready (rst excepted).

Arithmetic:
- The block performs no floating-point arithmetic itself. All sums come from the adder in the same cycle (single-cycle combinational path).
- Signs and denormals pass through unchanged.

Test Plan:
- Reset, then in_data=16'h3C00 (1.0) with in_last=1 -> out_valid=1 next cycle, out_sum=16'h3C00, out_count=1, out_ovf=0.
- Three beats 1.0, 1.0, 1.0, last on the third, out_ready=1 -> add_a sequence 0000/3C00/4000, out_sum=16'h4200 (3.0), out_count=3, in_ready=0 for exactly one cycle.
- Beats 16'h7BFF, 16'h7BFF with last -> add_v=1 on the second beat, out_sum=16'h7C00, out_ovf=1. The next packet 1.0 with last -> out_ovf=0.
- Result held with out_ready=0 for 5 cycles while in_valid=1 -> out_* stable, in_ready=0, no beat consumed. Raise out_ready -> the next packet's first beat is accepted in the cycle after the handshake with add_a=0.
- Two beats accepted, then rst=1 for one cycle, then 1.0 with last -> out_sum=16'h3C00, out_count=1; all outputs were at reset values in the cycle after rst.
- CNT_W=2, five 16'h0000 beats with last on the fifth -> out_count=3 (saturated), out_sum=16'h0000.
